// File: rtl/signed_bcd_entry.sv
// Keypad BCD entry (sign + DIGITS digits) -> reverse double-dabble -> NUM_W two's complement; SIGNED_BCD_SAT_EN clamps overflow.
// Result 11 edges after enter; strobes arriving while busy are dropped, never queued.
module signed_bcd_entry #(
  parameter int NUM_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  digit_valid,
  input  logic [3:0]            digit,
  input  logic                  sign_toggle,
  input  logic                  clear,
  input  logic                  enter,
  output logic [NUM_W-1:0]      num,
  output logic                  num_valid,
  output logic                  overflow,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   entry_bcd,
  output logic                  entry_neg
);

  localparam int CONV_W = 10;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int SR_W   = BCD_W + CONV_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int STEP_W = $clog2(CONV_W);

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DIGITS);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CONV_W - 1);
  localparam logic [CONV_W-1:0] POS_MAX   = CONV_W'(2 ** (NUM_W - 1) - 1);
  localparam logic [CONV_W-1:0] NEG_MAX   = CONV_W'(2 ** (NUM_W - 1));

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    CONV   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic               num_valid_q, num_valid_d;
  logic               ovf_q, ovf_d;

  logic [SR_W-1:0]    sr_step;
  logic [CONV_W-1:0]  mag;
  logic [CONV_W-1:0]  neg_mag;
  logic               out_of_range;

  // One reverse double-dabble step: shift right, then pull every BCD nibble >= 8 down by 3.
  always_comb begin
    sr_step = sr_q >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_step[CONV_W + 4*i +: 4] >= 4'd8)
        sr_step[CONV_W + 4*i +: 4] = sr_step[CONV_W + 4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    mag          = sr_q[CONV_W-1:0];
    neg_mag      = -mag;
    out_of_range = neg_q ? (mag > NEG_MAX) : (mag > POS_MAX);
  end

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    step_d      = step_q;
    num_d       = num_q;
    ovf_d       = ovf_q;
    num_valid_d = 1'b0;
    case (state_q)
      ENTRY: begin
        if (clear) begin
          bcd_d = '0;
          neg_d = 1'b0;
          cnt_d = '0;
        end else if (enter) begin
          sr_d    = {bcd_q, {CONV_W{1'b0}}};
          step_d  = '0;
          state_d = CONV;
        end else if (digit_valid) begin
          // An out-of-range digit or a full entry still consumes the edge.
          if (digit <= 4'd9 && cnt_q < CNT_MAX) begin
            bcd_d = {bcd_q[BCD_W-5:0], digit};
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sign_toggle) begin
          neg_d = ~neg_q;
        end
      end
      CONV: begin
        sr_d   = sr_step;
        step_d = step_q + 1'b1;
        if (step_q == STEP_LAST)
          state_d = RESULT;
      end
      RESULT: begin
        num_valid_d = 1'b1;
        ovf_d       = out_of_range;
        if (!out_of_range) begin
          num_d = neg_q ? neg_mag[NUM_W-1:0] : mag[NUM_W-1:0];
        end else begin
`ifdef SIGNED_BCD_SAT_EN
          num_d = neg_q ? {1'b1, {(NUM_W-1){1'b0}}} : {1'b0, {(NUM_W-1){1'b1}}};
`else
          num_d = num_q;
`endif
        end
        bcd_d   = '0;
        neg_d   = 1'b0;
        cnt_d   = '0;
        state_d = ENTRY;
      end
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ENTRY;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      sr_q        <= '0;
      step_q      <= '0;
      num_q       <= '0;
      num_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      step_q      <= step_d;
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign num       = num_q;
  assign num_valid = num_valid_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != ENTRY);
  assign entry_bcd = bcd_q;
  assign entry_neg = neg_q;

endmodule

// File: tb/tb_signed_bcd_entry.sv
// Bench for signed_bcd_entry: directed scenarios plus randomized entry sequences against a decimal reference model.
module tb_signed_bcd_entry;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        sign_toggle = 1'b0;
  logic        clear = 1'b0;
  logic        enter = 1'b0;
  logic [7:0]  num;
  logic        num_valid;
  logic        overflow;
  logic        busy;
  logic [11:0] entry_bcd;
  logic        entry_neg;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: typed-in digits as a list of decimal values, sign, last result.
  int         m_dig[$];
  bit         m_neg = 1'b0;
  logic [7:0] m_num = 8'h00;
  logic       m_ovf = 1'b0;

  signed_bcd_entry #(.NUM_W(8), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
    .sign_toggle(sign_toggle), .clear(clear), .enter(enter), .num(num),
    .num_valid(num_valid), .overflow(overflow), .busy(busy),
    .entry_bcd(entry_bcd), .entry_neg(entry_neg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] model_bcd();
    logic [11:0] r = 12'h000;
    foreach (m_dig[i]) r = {r[7:0], 4'(m_dig[i])};
    return r;
  endfunction

  function automatic void model_convert();
    int val = 0;
    int sv;
    foreach (m_dig[i]) val = val * 10 + m_dig[i];
    sv = m_neg ? -val : val;
    if (sv > 127 || sv < -128) begin
      m_ovf = 1'b1;
`ifdef SIGNED_BCD_SAT_EN
      m_num = m_neg ? 8'h80 : 8'h7F;
`endif
    end else begin
      m_ovf = 1'b0;
      m_num = 8'(sv);
    end
    m_dig.delete();
    m_neg = 1'b0;
  endfunction

  task automatic key(input int d);
    digit = 4'(d);
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    if (d <= 9 && m_dig.size() < 3) m_dig.push_back(d);
  endtask

  task automatic sign();
    sign_toggle = 1'b1;
    tick();
    sign_toggle = 1'b0;
    m_neg = ~m_neg;
  endtask

  task automatic clr();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_dig.delete();
    m_neg = 1'b0;
  endtask

  // Pulses enter (optionally with a competing digit), waits for num_valid with a bound.
  task automatic run_enter(input int also_digit, output int lat, output int busy_cnt, output logic nv_after);
    enter = 1'b1;
    if (also_digit >= 0) begin
      digit = 4'(also_digit);
      digit_valid = 1'b1;
    end
    tick();
    enter = 1'b0;
    digit_valid = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    while (num_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
      if (busy === 1'b1) busy_cnt++;
    end
    model_convert();
    tick();
    nv_after = num_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({num, num_valid, overflow, busy, entry_bcd, entry_neg} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_state got num=%h nv=%b ovf=%b busy=%b bcd=%h neg=%b want all 0",
               num, num_valid, overflow, busy, entry_bcd, entry_neg);
    end
  endtask

  task automatic test_spec_vectors();
    int lat, bc;
    logic nva;
    // 127 is the largest positive value
    key(1); key(2); key(7);
    run_enter(-1, lat, bc, nva);
    n_cmp++;
    if (lat !== 11 || bc !== 11 || nva !== 1'b0) begin
      n_bad++;
      $display("FAIL latency got lat=%0d busy_cycles=%0d nv_after=%b want 11 11 0", lat, bc, nva);
    end
    n_cmp++;
    if ({num, overflow} !== {8'h7F, 1'b0}) begin
      n_bad++;
      $display("FAIL pos127 got num=%h ovf=%b want 7f 0", num, overflow);
    end
    sign(); key(1); key(2); key(8);
    n_cmp++;
    if ({entry_neg, entry_bcd} !== {1'b1, 12'h128}) begin
      n_bad++;
      $display("FAIL neg128_entry got neg=%b bcd=%h want 1 128", entry_neg, entry_bcd);
    end
    run_enter(-1, lat, bc, nva);
    n_cmp++;
    if ({num, overflow, entry_neg, entry_bcd} !== {8'h80, 1'b0, 1'b0, 12'h000}) begin
      n_bad++;
      $display("FAIL neg128 got num=%h ovf=%b neg=%b bcd=%h want 80 0 0 000", num, overflow, entry_neg, entry_bcd);
    end
    key(5);
    run_enter(-1, lat, bc, nva);
    n_cmp++;
    if ({num, overflow} !== {8'h05, 1'b0}) begin
      n_bad++;
      $display("FAIL five got num=%h ovf=%b want 05 0", num, overflow);
    end
    key(2); key(0); key(0);
    run_enter(-1, lat, bc, nva);
    n_cmp++;
    if ({num, overflow} !== {m_num, 1'b1} || num_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow200 got num=%h ovf=%b want %h 1", num, overflow, m_num);
    end
    key(9); key(9); key(9); key(5);
    n_cmp++;
    if (entry_bcd !== 12'h999) begin
      n_bad++;
      $display("FAIL fourth_key got bcd=%h want 999", entry_bcd);
    end
    clr();
    key(10);
    n_cmp++;
    if (entry_bcd !== 12'h000) begin
      n_bad++;
      $display("FAIL digit_a got bcd=%h want 000", entry_bcd);
    end
    sign();
    run_enter(-1, lat, bc, nva);
    n_cmp++;
    if ({num, overflow} !== {8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL minus_zero got num=%h ovf=%b want 00 0", num, overflow);
    end
    key(4);
    run_enter(7, lat, bc, nva);
    n_cmp++;
    if ({num, overflow, entry_bcd} !== {8'h04, 1'b0, 12'h000} || lat !== 11) begin
      n_bad++;
      $display("FAIL enter_vs_digit got num=%h ovf=%b bcd=%h lat=%0d want 04 0 000 11", num, overflow, entry_bcd, lat);
    end
  endtask

  task automatic test_busy_drop();
    int n = 0;
    int extra = 0;
    key(4); key(2);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    digit = 4'd3; digit_valid = 1'b1; tick(); digit_valid = 1'b0;
    sign_toggle = 1'b1; tick(); sign_toggle = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    enter = 1'b1; tick(); enter = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || entry_bcd !== 12'h042 || entry_neg !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_hold got busy=%b bcd=%h neg=%b want 1 042 0", busy, entry_bcd, entry_neg);
    end
    while (num_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    model_convert();
    n_cmp++;
    if ({num_valid, num, overflow} !== {1'b1, 8'd42, 1'b0} || n !== 7) begin
      n_bad++;
      $display("FAIL busy_result got nv=%b num=%h ovf=%b wait=%0d want 1 2a 0 7", num_valid, num, overflow, n);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (num_valid === 1'b1) extra++;
    end
    n_cmp++;
    if (extra !== 0 || entry_bcd !== 12'h000 || entry_neg !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_queued got extra_pulses=%0d bcd=%h neg=%b want 0 000 0", extra, entry_bcd, entry_neg);
    end
  endtask

  task automatic test_reset_mid_conv();
    int pulses = 0;
    key(9);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({num, num_valid, overflow, busy, entry_bcd, entry_neg} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_mid_conv got num=%h nv=%b ovf=%b busy=%b bcd=%h neg=%b want all 0",
               num, num_valid, overflow, busy, entry_bcd, entry_neg);
    end
    tick();
    reset = 1'b0;
    m_dig.delete();
    m_neg = 1'b0;
    m_num = 8'h00;
    m_ovf = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (num_valid === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || num !== 8'h00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_abort got pulses=%0d num=%h busy=%b want 0 00 0", pulses, num, busy);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic nva;
    for (int r = 0; r < 40; r++) begin
      int cycles = $urandom_range(1, 8);
      for (int c = 0; c < cycles; c++) begin
        bit c_clr = ($urandom % 12) == 0;
        bit c_dv  = ($urandom % 2) == 0;
        bit c_sg  = ($urandom % 4) == 0;
        int c_d   = $urandom % 12;
        clear = c_clr; digit_valid = c_dv; digit = 4'(c_d); sign_toggle = c_sg;
        tick();
        clear = 1'b0; digit_valid = 1'b0; sign_toggle = 1'b0;
        if (c_clr) begin
          m_dig.delete();
          m_neg = 1'b0;
        end else if (c_dv) begin
          if (c_d <= 9 && m_dig.size() < 3) m_dig.push_back(c_d);
        end else if (c_sg) begin
          m_neg = ~m_neg;
        end
        n_cmp++;
        if ({entry_neg, entry_bcd} !== {m_neg, model_bcd()}) begin
          n_bad++;
          $display("FAIL rand_entry r=%0d got neg=%b bcd=%h want %b %h", r, entry_neg, entry_bcd, m_neg, model_bcd());
        end
      end
      run_enter(-1, lat, bc, nva);
      n_cmp++;
      if ({num, overflow} !== {m_num, m_ovf} || lat !== 11 || nva !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_result r=%0d got num=%h ovf=%b lat=%0d want %h %b 11", r, num, overflow, lat, m_num, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_busy_drop();
    test_reset_mid_conv();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
